mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, beside the combinational ALU.
//  - Takes the same forwarded Operand1/Operand2 as the ALU.
//  - Runs a multi-cycle shift-add or restoring-divide sequence.
//  - Holds Busy so the hazard unit stalls IF/ID/EX.
//  - Returns a registered Result with a one-cycle Done pulse for the EX/MEM mux.

---
 rtl/mul_div_unit_pkg.sv | 31 +++
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Operation codes equal the RV32M funct3 field.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic op_signed1(md_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed2(md_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide beside the EX-stage ALU: shift-add multiply and
// restoring divide share one 2*XLEN shift register. Busy stalls the pipe; Done pulses once.
// Handshake: Start is accepted only in IDLE when Flush is low; Busy is high from the
// cycle after acceptance until the result is formed; Done is a one-cycle pulse with Result valid.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      MulDivContrl,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output md_state_e       dbg_state
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [XLEN-1:0]   op1_q, op1_d, opb_q, opb_d, result_q, result_d;
  logic [2*XLEN-1:0] sh_q, sh_d, sh_step;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s1_q, s1_d, s2_q, s2_d;

  logic              accept, is_div, last_iter, special, div_ge;
  logic [XLEN-1:0]   mag1, mag2, special_val, div_trial;
  logic [XLEN:0]     mul_sum;

  assign accept    = (state_q == ST_IDLE) && Start && !Flush;
  assign is_div    = op_q[2];
  assign last_iter = (cnt_q == CW'(XLEN - 1));
  assign mag1      = s1_q ? -op1_q : op1_q;
  assign mag2      = s2_q ? -opb_q : opb_q;

  // Post-processing: sign correction and result selection once the iterations finish.
  function automatic logic [XLEN-1:0] sign_fix(md_op_e op, logic s1, logic s2,
                                               logic [2*XLEN-1:0] sh);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    prod = (s1 ^ s2) ? -sh : sh;
    quot = (s1 ^ s2) ? -sh[XLEN-1:0] : sh[XLEN-1:0];
    rem  = s1 ? -sh[2*XLEN-1:XLEN] : sh[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                       sign_fix = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sign_fix = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              sign_fix = quot;
      default:                      sign_fix = rem;
    endcase
  endfunction

  // Divide-by-zero and signed overflow bypass the iterations entirely.
  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (is_div && (opb_q == '0)) begin
      special     = 1'b1;
      special_val = op_q[1] ? op1_q : '1;
    end else if (is_div && !op_q[0] && (op1_q == {1'b1, {(XLEN-1){1'b0}}}) && (opb_q == '1)) begin
      special     = 1'b1;
      special_val = op_q[1] ? '0 : op1_q;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, sh_q[2*XLEN-1:XLEN]} + (sh_q[0] ? {1'b0, opb_q} : '0);
    div_ge    = ({sh_q[2*XLEN-1:XLEN], sh_q[XLEN-1]} >= {1'b0, opb_q});
    div_trial = {sh_q[2*XLEN-2:XLEN], sh_q[XLEN-1]} - opb_q;
    if (is_div) begin
      sh_step = div_ge ? {div_trial, sh_q[XLEN-2:0], 1'b1} : {sh_q[2*XLEN-2:0], 1'b0};
    end else begin
      sh_step = {mul_sum, sh_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_PREP;
      ST_PREP: state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (last_iter) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (Flush) state_d = ST_IDLE;
  end

  always_comb begin
    Busy      = (state_q == ST_PREP) || (state_q == ST_CALC);
    Done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  assign Result = result_q;

  always_comb begin
    op_d     = op_q;
    op1_d    = op1_q;
    opb_d    = opb_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = md_op_e'(MulDivContrl);
          op1_d = Operand1;
          opb_d = Operand2;
          s1_d  = op_signed1(md_op_e'(MulDivContrl)) & Operand1[XLEN-1];
          s2_d  = op_signed2(md_op_e'(MulDivContrl)) & Operand2[XLEN-1];
        end
      end
      ST_PREP: begin
        cnt_d = '0;
        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
        if (is_div) begin
          sh_d  = {{XLEN{1'b0}}, mag1};
          opb_d = mag2;
        end else begin
          sh_d  = {{XLEN{1'b0}}, mag2};
          opb_d = mag1;
        end
        if (special && !Flush) result_d = special_val;
      end
      ST_CALC: begin
        sh_d  = sh_step;
        cnt_d = cnt_q + 1'b1;
        if (last_iter && !Flush) result_d = sign_fix(op_q, s1_q, s2_q, sh_step);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      op1_q    <= '0;
      opb_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      op1_q    <= op1_d;
      opb_q    <= opb_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, randomized operations
// against a 64-bit arithmetic reference model, and flush/reset/ignored-start scenarios.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, Start, Flush;
  logic [2:0]  MulDivContrl;
  logic [31:0] Operand1, Operand2;
  logic        Busy, Done;
  logic [31:0] Result;
  md_state_e   dbg_state;

  int          n_vec = 0;
  int          n_mis = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Flush(Flush),
    .MulDivContrl(MulDivContrl), .Operand1(Operand1), .Operand2(Operand2),
    .Busy(Busy), .Done(Done), .Result(Result), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // reference model: plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_model = '0;
    case (op)
      3'd0: begin p = sa * sb; ref_model = p[31:0]; end
      3'd1: begin p = sa * sb; ref_model = p[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, b}); ref_model = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; ref_model = p[63:32]; end
      3'd4: ref_model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(int'(a) / int'(b));
      3'd5: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_model = (b == 0) ? a : ovf ? 32'h0 : 32'(int'(a) % int'(b));
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return XLEN + 2;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_done: got Done with Result 0x%08h expected no Done", Result);
      end else begin
        check("result", Result, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic start_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    MulDivContrl = op;
    Operand1     = a;
    Operand2     = b;
    Start        = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    Operand1 = $urandom;
    Operand2 = $urandom;
  endtask

  task automatic run_op(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp_res, int exp_lat);
    int   lat;
    logic busy_ok;
    exp_q.push_back(exp_res);
    last_res = exp_res;
    start_op(op, a, b);
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (Done) begin
        lat     = k;
        busy_ok = busy_ok & !Busy;
        break;
      end
      busy_ok = busy_ok & Busy;
    end
    if (lat == 0) exp_q.delete();
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int          lat;
  } dir_t;

  dir_t dirs[12] = '{
    '{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
    '{"mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34},
    '{"mulhsu_ones",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
    '{"mulhu_ones",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
    '{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34},
    '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34},
    '{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        34},
    '{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         34},
    '{"divu_by0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2},
    '{"rem_by0",       3'd6, 32'd5,          32'd0,         32'd5,         2},
    '{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2},
    '{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2}
  };

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel, d0;
    logic        got;

    rst = 1'b1; Start = 1'b0; Flush = 1'b0;
    MulDivContrl = '0; Operand1 = '0; Operand2 = '0; last_res = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_result", Result, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    foreach (dirs[i]) run_op(dirs[i].name, dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].res, dirs[i].lat);

    for (int i = 0; i < 150; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15)) ^ {32{b[31]}};
      else if (sel == 3) a = 32'($urandom_range(0, 255));
      run_op("rnd", op, a, b, ref_model(op, a, b), ref_latency(op, a, b));
    end

    // Start together with Flush in IDLE: nothing accepted
    MulDivContrl = 3'd0; Operand1 = 32'd9; Operand2 = 32'd9;
    Start = 1'b1; Flush = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0; Flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", 32'(Busy), 32'd0);

    // Flush mid-divide: no Done, Result kept
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(Busy), 32'd0);
    check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
    check("flush_result_kept", Result, last_res);
    repeat (40) @(negedge clk);
    run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 34);

    // Start pulses while running are ignored; Start during DONE is ignored
    d0 = done_cnt;
    exp_q.push_back(ref_model(3'd5, 32'd1000000, 32'd37));
    last_res = ref_model(3'd5, 32'd1000000, 32'd37);
    start_op(3'd5, 32'd1000000, 32'd37);
    repeat (4) @(negedge clk);
    start_op(3'd0, $urandom, $urandom);
    repeat (14) @(negedge clk);
    start_op(3'd1, $urandom, $urandom);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Done) begin got = 1'b1; break; end
    end
    check("ignore_done_seen", 32'(got), 32'd1);
    start_op(3'd0, 32'd1, 32'd1);
    @(negedge clk);
    check("start_in_done_busy", 32'(Busy), 32'd0);
    check("start_in_done_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (40) @(negedge clk);
    check("ignore_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset mid-operation clears everything
    a = $urandom; b = $urandom;
    exp_q.push_back(ref_model(3'd3, a, b));
    start_op(3'd3, a, b);
    repeat (14) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", Result, 32'd0);
    repeat (2) @(negedge clk);
    run_op("post_rst_rem", 3'd6, 32'hFFFF_FF9C, 32'd7, ref_model(3'd6, 32'hFFFF_FF9C, 32'd7), 34);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
